rng_checker: RTL

- Receive-side companion to the 8-bit LFSR random number generator: consumes the generator's `out` stream and checks it against the same LFSR recurrence.
- Acquires lock from the live stream, flags and counts sequence errors, and detects the all-zero lockup value.
- Sits beside the rng in the design and in self-checking benches; it replaces `$monitor` eyeballing with hardware pass/fail status.

---
 rtl/rng_checker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rng_checker.sv
// Receive-side checker for the 8-bit LFSR rng stream (taps 8,6,5,4): lock, error count, zero lockup.
// Optional period measurement is compiled in with `define RNG_CHK_PERIOD_EN.
module rng_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned MISS_MAX = 3,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in,
    output logic             locked,
    output logic             mismatch,
    output logic             zero_err,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       period,
    output logic             period_valid
);

    typedef enum logic [1:0] {
        StSeed,
        StTrack,
        StLocked
    } state_e;

    localparam logic [3:0]       LockTgt = 4'(LOCK_CNT);
    localparam logic [3:0]       MissTgt = 4'(MISS_MAX);
    localparam logic [ERR_W-1:0] ErrMax  = '1;
    localparam logic [ERR_W-1:0] ErrOne  = ERR_W'(1);

    function automatic logic [7:0] step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    state_e     state;
    logic [7:0] pred;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;
    logic       hit;

    assign hit = (in == pred);

`ifdef RNG_CHK_PERIOD_EN
    logic [7:0] ref_val;
    logic [7:0] pcnt;
    logic       drop;

    // Lock is lost on this edge: the period measurement is abandoned.
    assign drop = !hit && (miss_cnt + 4'd1 == MissTgt);
`else
    assign period       = 8'h00;
    assign period_valid = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StSeed;
            pred      <= 8'h00;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
            zero_err  <= 1'b0;
            err_count <= '0;
`ifdef RNG_CHK_PERIOD_EN
            ref_val      <= 8'h00;
            pcnt         <= 8'h00;
            period       <= 8'h00;
            period_valid <= 1'b0;
`endif
        end else begin
            mismatch <= 1'b0;
`ifdef RNG_CHK_PERIOD_EN
            period_valid <= 1'b0;
`endif
            if (start) begin
                if (in == 8'h00) begin
                    zero_err <= 1'b1;
                end
                case (state)
                    StSeed: begin
                        if (in != 8'h00) begin
                            pred      <= step(in);
                            match_cnt <= 4'd0;
                            state     <= StTrack;
                        end
                    end
                    StTrack: begin
                        if (in == 8'h00) begin
                            state <= StSeed;
                        end else if (hit) begin
                            pred      <= step(in);
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LockTgt) begin
                                state    <= StLocked;
                                locked   <= 1'b1;
                                miss_cnt <= 4'd0;
`ifdef RNG_CHK_PERIOD_EN
                                ref_val <= in;
                                pcnt    <= 8'h00;
`endif
                            end
                        end else begin
                            // Out-of-sequence value before lock: silently resynchronise.
                            pred      <= step(in);
                            match_cnt <= 4'd0;
                        end
                    end
                    StLocked: begin
                        // Flywheel: a corrupted input never disturbs the prediction.
                        pred <= step(pred);
                        if (hit) begin
                            miss_cnt <= 4'd0;
                        end else begin
                            mismatch <= 1'b1;
                            if (err_count != ErrMax) begin
                                err_count <= err_count + ErrOne;
                            end
                            miss_cnt <= miss_cnt + 4'd1;
                            if (miss_cnt + 4'd1 == MissTgt) begin
                                locked    <= 1'b0;
                                miss_cnt  <= 4'd0;
                                match_cnt <= 4'd0;
                                if (in == 8'h00) begin
                                    state <= StSeed;
                                end else begin
                                    pred  <= step(in);
                                    state <= StTrack;
                                end
                            end
                        end
`ifdef RNG_CHK_PERIOD_EN
                        if (!drop) begin
                            if (pcnt == 8'hff) begin
                                period       <= 8'h00;
                                period_valid <= 1'b1;
                                ref_val      <= in;
                                pcnt         <= 8'h00;
                            end else if (in == ref_val) begin
                                period       <= pcnt + 8'd1;
                                period_valid <= 1'b1;
                                pcnt         <= 8'h00;
                            end else begin
                                pcnt <= pcnt + 8'd1;
                            end
                        end
`endif
                    end
                    default: begin
                        state <= StSeed;
                    end
                endcase
            end
        end
    end

endmodule
